hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline controller for the 5-stage core (F/D/E/M/W); sequences the stage registers (incl. decode's).
//  Drives per-stage enables, flushes and E-stage operand forwarding selects.
//  Resolves load-use hazards, taken-branch redirects, data-memory wait states and end-of-program drain.
//  Sits beside the datapath; every stage register's en/valid is driven only from here.
// PARAMETERS
//  REG_SIZE      5    register address width (= `REG_SIZE)
//  DRAIN_CYCLES  2    cycles after finish leaves E before halted (M + W)
//  WAIT_LIMIT    255  max consecutive dmem wait cycles before timeout; 8-bit counter
// PORTS
//  clk          in   1         clock; all state updates on posedge
//  reset        in   1         synchronous, active-low reset
//  raddr1D      in   REG_SIZE  rs1 of instr in D
//  raddr2D      in   REG_SIZE  rs2 of instr in D
//  raddr1E      in   REG_SIZE  rs1 of instr in E
//  raddr2E      in   REG_SIZE  rs2 of instr in E
//  writeRegE    in   REG_SIZE  rd of instr in E
//  regWriteE    in   1         E instr writes rd
//  mem2regE     in   1         E instr is a load
//  validE       in   1         E holds a real instr
//  pcSrcE       in   1         taken branch/jump resolved in E
//  finishE      in   1         E instr is SYSTEM/illegal (end of program)
//  writeRegM    in   REG_SIZE  rd in M
//  regWriteM    in   1         M instr writes rd
//  dmemReqM     in   1         M stage accessing dmem this cycle
//  dmemReadyM   in   1         dmem completes access this cycle
//  writeRegW    in   REG_SIZE  rd in W
//  regWriteW    in   1         W instr writes rd
//  enF,enD,enE,enM  out 1      stage-register enables (1 = advance)
//  flushD       out  1         load validD=0 into the D register
//  flushE       out  1         load validE=0 into the E register (bubble)
//  fwdAE,fwdBE  out  2         operand select: 00 regfile, 01 from W, 10 from M
//  halted       out  1         pipeline drained, core stopped
//  memTimeout   out  1         sticky: dmem wait exceeded WAIT_LIMIT
// BEHAVIOUR
//  States: RUN, MEMWAIT, DRAIN, HALTED. reset==0 at posedge -> RUN, waitCnt=0, drainCnt=0, memTimeout=0.
//  Outputs are combinational from state + inputs. While reset==0:
//    enables=0, flushD=flushE=1, fwd*=00, halted=0, memTimeout=0.
//  Forwarding (all states): fwdAE=10 if regWriteM && writeRegM!=0 && writeRegM==raddr1E;
//    else 01 if regWriteW && writeRegW!=0 && writeRegW==raddr1E; else 00. M beats W. fwdBE same on raddr2E.
//  Priority within RUN, highest first:
//   1 memStall = dmemReqM && !dmemReadyM: all en=0, no flush; -> MEMWAIT, waitCnt=1.
//   2 finishE && validE: enF=enD=0, enE=enM=1, flushE=1; -> DRAIN, drainCnt=0.
//   3 pcSrcE && validE: all en=1, flushD=flushE=1 (two-instr penalty).
//   4 loadUse = validE && mem2regE && regWriteE && writeRegE!=0
//       && (writeRegE==raddr1D || writeRegE==raddr2D):
//     enF=enD=0, enE=enM=1, flushE=1; exactly one bubble.
//   5 else all en=1, no flush.
//  MEMWAIT: all en=0; dmemReadyM -> RUN, waitCnt=0, same cycle behaves as RUN item 5 (all en=1).
//    Else waitCnt++; on waitCnt==WAIT_LIMIT && !dmemReadyM -> memTimeout=1, -> HALTED.
//  DRAIN: enF=enD=0, flushE=1, enE=1; enM=!(dmemReqM && !dmemReadyM).
//    drainCnt++ only when enM=1. drainCnt==DRAIN_CYCLES-1 and enM -> HALTED.
//  HALTED: all en=0, flushD=flushE=1, halted=1; left only by reset.
//  Branch and finish in the same E instr is illegal; finish wins.
//  Reset mid-MEMWAIT/DRAIN: returns to RUN, counters and memTimeout cleared.
// STRUCTURE
//  Shared header/package: ctrl_state_t enum {RUN,MEMWAIT,DRAIN,HALTED}.
//  Also FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10, alongside existing `OPCODE_*/`ALU_* defines.
//  One sub-module: fwd_unit (pure combinational, instantiated twice for A/B).
//  State, waitCnt and drainCnt are all in hazard_ctrl.
// TESTING
//  lw x5 in E (mem2regE=1), D rs1=5 -> 1 cycle enF=enD=0, flushE=1; next cycle all en=1.
//  lw x0 in E, D rs1=0 -> no stall; add in M writes x3, E rs2=3, W also writes x3 -> fwdBE=10.
//  pcSrcE=1 & loadUse same cycle -> flushD=flushE=1, all en=1, no stall.
//  dmemReqM=1, ready after 3 cycles -> en=0 for 3 cycles, 4th all en=1; WAIT_LIMIT=4, never ready -> memTimeout=1, halted=1.
//  finishE=1 validE=1 -> DRAIN; halted asserts 2 cycles later (3 if one dmem wait); stays until reset.
//  reset=0 during DRAIN -> next cycle state RUN, halted=0, all en=1 once reset=1.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } ctrl_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  function automatic logic mem_stall(input logic req, input logic ready);
    return req && !ready;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// E-stage operand forwarding select for one source register; M has priority over W.
module hazard_ctrl_fwd_unit
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_SIZE = 5
) (
  input  logic [REG_SIZE-1:0] raddr,
  input  logic [REG_SIZE-1:0] writeRegM,
  input  logic                regWriteM,
  input  logic [REG_SIZE-1:0] writeRegW,
  input  logic                regWriteW,
  output logic [1:0]          sel
);

  always_comb begin
    sel = FWD_RF;
    // x0 is hardwired to zero, so a write to it is never forwarded
    if (regWriteM && (writeRegM != '0) && (writeRegM == raddr)) begin
      sel = FWD_M;
    end else if (regWriteW && (writeRegW != '0) && (writeRegW == raddr)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline controller for the 5-stage core: stage enables, flushes, forwarding,
// load-use / branch / dmem-wait handling and end-of-program drain.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_SIZE     = 5,
  parameter int DRAIN_CYCLES = 2,
  parameter int WAIT_LIMIT   = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_SIZE-1:0] raddr1D,
  input  logic [REG_SIZE-1:0] raddr2D,
  input  logic [REG_SIZE-1:0] raddr1E,
  input  logic [REG_SIZE-1:0] raddr2E,
  input  logic [REG_SIZE-1:0] writeRegE,
  input  logic                regWriteE,
  input  logic                mem2regE,
  input  logic                validE,
  input  logic                pcSrcE,
  input  logic                finishE,
  input  logic [REG_SIZE-1:0] writeRegM,
  input  logic                regWriteM,
  input  logic                dmemReqM,
  input  logic                dmemReadyM,
  input  logic [REG_SIZE-1:0] writeRegW,
  input  logic                regWriteW,
  output logic                enF,
  output logic                enD,
  output logic                enE,
  output logic                enM,
  output logic                flushD,
  output logic                flushE,
  output logic [1:0]          fwdAE,
  output logic [1:0]          fwdBE,
  output logic                halted,
  output logic                memTimeout
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  ctrl_state_t        state_reg;
  logic [7:0]         wait_cnt_reg;
  logic [DRAIN_W-1:0] drain_cnt_reg;
  logic               mem_timeout_reg;

  logic       stall_m;
  logic       finish_valid;
  logic       branch_valid;
  logic       load_use;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  assign stall_m      = mem_stall(dmemReqM, dmemReadyM);
  assign finish_valid = finishE && validE;
  assign branch_valid = pcSrcE && validE;
  assign load_use     = validE && mem2regE && regWriteE && (writeRegE != '0)
                        && ((writeRegE == raddr1D) || (writeRegE == raddr2D));

  hazard_ctrl_fwd_unit #(.REG_SIZE(REG_SIZE)) u_fwd_a (
    .raddr     (raddr1E),
    .writeRegM (writeRegM),
    .regWriteM (regWriteM),
    .writeRegW (writeRegW),
    .regWriteW (regWriteW),
    .sel       (fwd_a)
  );

  hazard_ctrl_fwd_unit #(.REG_SIZE(REG_SIZE)) u_fwd_b (
    .raddr     (raddr2E),
    .writeRegM (writeRegM),
    .regWriteM (regWriteM),
    .writeRegW (writeRegW),
    .regWriteW (regWriteW),
    .sel       (fwd_b)
  );

  assign fwdAE      = reset ? fwd_a : FWD_RF;
  assign fwdBE      = reset ? fwd_b : FWD_RF;
  assign halted     = reset && (state_reg == HALTED);
  assign memTimeout = reset && mem_timeout_reg;

  always_comb begin
    enF    = 1'b0;
    enD    = 1'b0;
    enE    = 1'b0;
    enM    = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    if (!reset) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else begin
      case (state_reg)
        RUN: begin
          if (stall_m) begin
            // everything frozen, nothing flushed
          end else if (finish_valid) begin
            enE    = 1'b1;
            enM    = 1'b1;
            flushE = 1'b1;
          end else if (branch_valid) begin
            // a taken branch squashes the load-use stall: both younger instrs die anyway
            enF    = 1'b1;
            enD    = 1'b1;
            enE    = 1'b1;
            enM    = 1'b1;
            flushD = 1'b1;
            flushE = 1'b1;
          end else if (load_use) begin
            enE    = 1'b1;
            enM    = 1'b1;
            flushE = 1'b1;
          end else begin
            enF = 1'b1;
            enD = 1'b1;
            enE = 1'b1;
            enM = 1'b1;
          end
        end
        MEMWAIT: begin
          if (dmemReadyM) begin
            enF = 1'b1;
            enD = 1'b1;
            enE = 1'b1;
            enM = 1'b1;
          end
        end
        DRAIN: begin
          enE    = 1'b1;
          flushE = 1'b1;
          enM    = !stall_m;
        end
        HALTED: begin
          flushD = 1'b1;
          flushE = 1'b1;
        end
        default: begin
          flushD = 1'b1;
          flushE = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= 8'd0;
      drain_cnt_reg   <= '0;
      mem_timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (stall_m) begin
            state_reg    <= MEMWAIT;
            wait_cnt_reg <= 8'd1;
          end else if (finish_valid) begin
            state_reg     <= DRAIN;
            drain_cnt_reg <= '0;
          end
        end
        MEMWAIT: begin
          if (dmemReadyM) begin
            state_reg    <= RUN;
            wait_cnt_reg <= 8'd0;
          end else if (wait_cnt_reg == 8'(WAIT_LIMIT)) begin
            mem_timeout_reg <= 1'b1;
            state_reg       <= HALTED;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        DRAIN: begin
          // M and W retire one drain step per cycle that M actually advances
          if (enM) begin
            drain_cnt_reg <= drain_cnt_reg + DRAIN_W'(1);
            if (drain_cnt_reg == DRAIN_W'(DRAIN_CYCLES - 1)) begin
              state_reg <= HALTED;
            end
          end
        end
        HALTED: begin
          state_reg <= HALTED;
        end
        default: begin
          state_reg <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector scoreboard bench for hazard_ctrl (WAIT_LIMIT=4, DRAIN_CYCLES=2).
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] raddr1D, raddr2D, raddr1E, raddr2E, writeRegE, writeRegM, writeRegW;
  logic       regWriteE, mem2regE, validE, pcSrcE, finishE;
  logic       regWriteM, dmemReqM, dmemReadyM, regWriteW;
  logic       enF, enD, enE, enM, flushD, flushE, halted, memTimeout;
  logic [1:0] fwdAE, fwdBE;

  typedef struct {
    string      name;
    logic [3:0] en;
    logic       fd;
    logic       fe;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       h;
    logic       mt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  hazard_ctrl #(.REG_SIZE(5), .DRAIN_CYCLES(2), .WAIT_LIMIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .raddr1D    (raddr1D),
    .raddr2D    (raddr2D),
    .raddr1E    (raddr1E),
    .raddr2E    (raddr2E),
    .writeRegE  (writeRegE),
    .regWriteE  (regWriteE),
    .mem2regE   (mem2regE),
    .validE     (validE),
    .pcSrcE     (pcSrcE),
    .finishE    (finishE),
    .writeRegM  (writeRegM),
    .regWriteM  (regWriteM),
    .dmemReqM   (dmemReqM),
    .dmemReadyM (dmemReadyM),
    .writeRegW  (writeRegW),
    .regWriteW  (regWriteW),
    .enF        (enF),
    .enD        (enD),
    .enE        (enE),
    .enM        (enM),
    .flushD     (flushD),
    .flushE     (flushE),
    .fwdAE      (fwdAE),
    .fwdBE      (fwdBE),
    .halted     (halted),
    .memTimeout (memTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge and drive idle inputs.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    reset = 1'b1;
    raddr1D = '0; raddr2D = '0; raddr1E = '0; raddr2E = '0;
    writeRegE = '0; writeRegM = '0; writeRegW = '0;
    regWriteE = 1'b0; mem2regE = 1'b0; validE = 1'b0; pcSrcE = 1'b0; finishE = 1'b0;
    regWriteM = 1'b0; dmemReqM = 1'b0; dmemReadyM = 1'b0; regWriteW = 1'b0;
  endtask

  task automatic push_exp(input string name, input logic [3:0] en, input logic fd,
                          input logic fe, input logic [1:0] fa, input logic [1:0] fb,
                          input logic h, input logic mt);
    exp_t e;
    e.name = name; e.en = en; e.fd = fd; e.fe = fe;
    e.fa = fa; e.fb = fb; e.h = h; e.mt = mt;
    exp_q.push_back(e);
  endtask

  // Monitor: combinational outputs are sampled on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      logic [3:0] got_en;
      e = exp_q.pop_front();
      got_en = {enF, enD, enE, enM};
      checks++;
      if (got_en !== e.en || flushD !== e.fd || flushE !== e.fe || fwdAE !== e.fa ||
          fwdBE !== e.fb || halted !== e.h || memTimeout !== e.mt) begin
        failures++;
        $display("FAIL %s: got en=%b fd=%b fe=%b fa=%b fb=%b h=%b mt=%b, want en=%b fd=%b fe=%b fa=%b fb=%b h=%b mt=%b",
                 e.name, got_en, flushD, flushE, fwdAE, fwdBE, halted, memTimeout,
                 e.en, e.fd, e.fe, e.fa, e.fb, e.h, e.mt);
      end else begin
        $display("%s ok: en=%b fd=%b fe=%b fa=%b fb=%b h=%b mt=%b",
                 e.name, got_en, flushD, flushE, fwdAE, fwdBE, halted, memTimeout);
      end
    end
  end

  initial begin
    next_cycle();
    reset = 1'b0; regWriteM = 1'b1; writeRegM = 5'd3; raddr1E = 5'd3;
    push_exp("reset", 4'b0000, 1, 1, 2'b00, 2'b00, 0, 0);

    next_cycle();
    push_exp("run_idle", 4'b1111, 0, 0, 2'b00, 2'b00, 0, 0);

    next_cycle();
    pcSrcE = 1'b1;
    push_exp("br_invalid", 4'b1111, 0, 0, 2'b00, 2'b00, 0, 0);

    next_cycle();
    validE = 1'b1; mem2regE = 1'b1; regWriteE = 1'b1; writeRegE = 5'd5; raddr1D = 5'd5;
    push_exp("lu_stall", 4'b0011, 0, 1, 2'b00, 2'b00, 0, 0);

    next_cycle();
    push_exp("lu_after", 4'b1111, 0, 0, 2'b00, 2'b00, 0, 0);

    next_cycle();
    validE = 1'b1; mem2regE = 1'b1; regWriteE = 1'b1; writeRegE = 5'd0; raddr1D = 5'd0;
    regWriteM = 1'b1; writeRegM = 5'd3; raddr2E = 5'd3; regWriteW = 1'b1; writeRegW = 5'd3;
    push_exp("lw_x0_fwd_m", 4'b1111, 0, 0, 2'b00, 2'b10, 0, 0);

    next_cycle();
    regWriteW = 1'b1; writeRegW = 5'd7; raddr1E = 5'd7;
    regWriteM = 1'b1; writeRegM = 5'd8; raddr2E = 5'd8;
    push_exp("fwd_w_a", 4'b1111, 0, 0, 2'b01, 2'b10, 0, 0);

    next_cycle();
    regWriteM = 1'b1; writeRegM = 5'd0; raddr1E = 5'd0; regWriteW = 1'b0; writeRegW = 5'd9;
    raddr2E = 5'd9;
    push_exp("fwd_none", 4'b1111, 0, 0, 2'b00, 2'b00, 0, 0);

    next_cycle();
    validE = 1'b1; pcSrcE = 1'b1; mem2regE = 1'b1; regWriteE = 1'b1; writeRegE = 5'd6;
    raddr2D = 5'd6;
    push_exp("br_over_lu", 4'b1111, 1, 1, 2'b00, 2'b00, 0, 0);

    next_cycle();
    validE = 1'b1; mem2regE = 1'b1; regWriteE = 1'b1; writeRegE = 5'd6; raddr2D = 5'd6;
    push_exp("lu_rs2", 4'b0011, 0, 1, 2'b00, 2'b00, 0, 0);

    next_cycle();
    dmemReqM = 1'b1;
    push_exp("mw_0", 4'b0000, 0, 0, 2'b00, 2'b00, 0, 0);
    next_cycle();
    dmemReqM = 1'b1; regWriteM = 1'b1; writeRegM = 5'd4; raddr1E = 5'd4;
    push_exp("mw_1_fwd", 4'b0000, 0, 0, 2'b10, 2'b00, 0, 0);
    next_cycle();
    dmemReqM = 1'b1;
    push_exp("mw_2", 4'b0000, 0, 0, 2'b00, 2'b00, 0, 0);
    next_cycle();
    dmemReqM = 1'b1; dmemReadyM = 1'b1;
    push_exp("mw_done", 4'b1111, 0, 0, 2'b00, 2'b00, 0, 0);
    next_cycle();
    push_exp("mw_run", 4'b1111, 0, 0, 2'b00, 2'b00, 0, 0);

    next_cycle();
    validE = 1'b1; finishE = 1'b1; pcSrcE = 1'b1;
    push_exp("fin_over_br", 4'b0011, 0, 1, 2'b00, 2'b00, 0, 0);
    next_cycle();
    dmemReqM = 1'b1;
    push_exp("drain_wait", 4'b0010, 0, 1, 2'b00, 2'b00, 0, 0);
    next_cycle();
    push_exp("drain_0", 4'b0011, 0, 1, 2'b00, 2'b00, 0, 0);
    next_cycle();
    push_exp("drain_1", 4'b0011, 0, 1, 2'b00, 2'b00, 0, 0);
    next_cycle();
    push_exp("halted", 4'b0000, 1, 1, 2'b00, 2'b00, 1, 0);
    next_cycle();
    validE = 1'b1; finishE = 1'b1; dmemReadyM = 1'b1;
    push_exp("halted_stay", 4'b0000, 1, 1, 2'b00, 2'b00, 1, 0);
    next_cycle();
    reset = 1'b0;
    push_exp("rst_halted", 4'b0000, 1, 1, 2'b00, 2'b00, 0, 0);
    next_cycle();
    push_exp("run_after_halt", 4'b1111, 0, 0, 2'b00, 2'b00, 0, 0);

    next_cycle();
    validE = 1'b1; finishE = 1'b1;
    push_exp("fin2", 4'b0011, 0, 1, 2'b00, 2'b00, 0, 0);
    next_cycle();
    push_exp("drain2_0", 4'b0011, 0, 1, 2'b00, 2'b00, 0, 0);
    next_cycle();
    reset = 1'b0;
    push_exp("rst_drain", 4'b0000, 1, 1, 2'b00, 2'b00, 0, 0);
    next_cycle();
    push_exp("run_after_drain", 4'b1111, 0, 0, 2'b00, 2'b00, 0, 0);

    for (int i = 0; i < 5; i++) begin
      next_cycle();
      dmemReqM = 1'b1;
      push_exp($sformatf("to_wait%0d", i), 4'b0000, 0, 0, 2'b00, 2'b00, 0, 0);
    end
    next_cycle();
    push_exp("timeout", 4'b0000, 1, 1, 2'b00, 2'b00, 1, 1);
    next_cycle();
    reset = 1'b0;
    push_exp("rst_timeout", 4'b0000, 1, 1, 2'b00, 2'b00, 0, 0);
    next_cycle();
    push_exp("mt_cleared", 4'b1111, 0, 0, 2'b00, 2'b00, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      $display("FAIL drain_queue: %0d expectations unchecked, want 0", exp_q.size());
      $fatal(1, "scoreboard did not drain");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
